// File: rtl/gray_mem_server.sv
// gray_mem_server: grayscale frame store loaded from a host byte stream, read back by the filter
//   clk, rst_n            clock, asynchronous active-low reset
//   load_valid/load_data  host pixel stream (raster order from address 0); load_ready while loading
//   gray_req/gray_addr    filter read request; gray_data registered, 1-cycle latency
//   gray_ready            frame resident and read port live
//   ipf_finish            filter done, parks the block until reload
//   reload                1-cycle pulse starting a new frame load (honoured only when done)
//   load_sum              only with GRAY_LOAD_CHECKSUM_EN: 16-bit sum of loaded pixels
module gray_mem_server #(
    parameter int In_Width   = 8,
    parameter int Addr_Width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [In_Width-1:0]   load_data,
    output logic                  load_ready,
    output logic                  gray_ready,
    input  logic                  gray_req,
    input  logic [Addr_Width-1:0] gray_addr,
    output logic [In_Width-1:0]   gray_data,
    input  logic                  ipf_finish,
    input  logic                  reload
`ifdef GRAY_LOAD_CHECKSUM_EN
    ,output logic [15:0]          load_sum
`endif
);
    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]            state;
    logic [Addr_Width-1:0] wr_ptr;
    logic [In_Width-1:0]   mem [2**Addr_Width];
    logic                  wr_en;
    logic                  rd_en;
    logic                  restart;
    assign wr_en      = (state == LOAD) && load_valid;
    assign rd_en      = (state == SERVE) && gray_req;
    assign restart    = (state == DONE) && reload;
    assign load_ready = (state == LOAD);
    assign gray_ready = (state == SERVE);
    // frame storage is deliberately not reset; a reset invalidates it by forcing a reload
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= load_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= LOAD;
            wr_ptr    <= '0;
            gray_data <= '0;
        end else begin
            if (wr_en) begin
                // pointer wraps to 0 naturally on the last address
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == {Addr_Width{1'b1}}) state <= SERVE;
            end
            if (rd_en) gray_data <= mem[gray_addr];
            if (state == SERVE && ipf_finish) state <= DONE;
            if (restart) begin
                state  <= LOAD;
                wr_ptr <= '0;
            end
        end
`ifdef GRAY_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) load_sum <= '0;
        else if (restart) load_sum <= '0;
        else if (wr_en) load_sum <= load_sum + 16'(load_data);
`endif
endmodule
